// File: rtl/attitude_pkg.sv
// Shared types and constants for the attitude angle scheduler.
package attitude_pkg;

    localparam int ANGLE_W  = 16;
    localparam int SAMPLE_W = 16;
    localparam int DROP_W   = 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_P_START = 3'd1,
        S_P_WAIT  = 3'd2,
        S_GAP     = 3'd3,
        S_R_START = 3'd4,
        S_R_WAIT  = 3'd5,
        S_PUBLISH = 3'd6
    } att_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == {DROP_W{1'b1}}) ? v : v + {{(DROP_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/attitude_sample_slot.sv
// Single-entry, latest-wins pending sample register with a saturating
// count of samples lost by being overwritten before they were consumed.
module attitude_sample_slot
    import attitude_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                wr,
    input  logic                consume,
    input  logic [SAMPLE_W-1:0] ax,
    input  logic [SAMPLE_W-1:0] ay,
    input  logic [SAMPLE_W-1:0] az,
    output logic                pv,
    output logic [SAMPLE_W-1:0] px,
    output logic [SAMPLE_W-1:0] py,
    output logic [SAMPLE_W-1:0] pz,
    output logic [DROP_W-1:0]   drop_cnt
);

    logic                pv_r;
    logic [SAMPLE_W-1:0] px_r;
    logic [SAMPLE_W-1:0] py_r;
    logic [SAMPLE_W-1:0] pz_r;
    logic [DROP_W-1:0]   drop_r;

    // Slot fill/overwrite/consume; an overwrite of an unconsumed entry is a drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            pv_r   <= 1'b0;
            px_r   <= {SAMPLE_W{1'b0}};
            py_r   <= {SAMPLE_W{1'b0}};
            pz_r   <= {SAMPLE_W{1'b0}};
            drop_r <= {DROP_W{1'b0}};
        end else if (wr) begin
            px_r <= ax;
            py_r <= ay;
            pz_r <= az;
            pv_r <= 1'b1;
            if (pv_r && !consume) begin
                drop_r <= sat_inc(drop_r);
            end else begin
                drop_r <= drop_r;
            end
        end else if (consume) begin
            pv_r <= 1'b0;
        end else begin
            pv_r <= pv_r;
        end
    end

    assign pv       = pv_r;
    assign px       = px_r;
    assign py       = py_r;
    assign pz       = pz_r;
    assign drop_cnt = drop_r;

endmodule

// File: rtl/attitude_angle_sched.sv
// Shares one cordic_angle engine between the pitch and roll jobs of each
// accelerometer sample, holds one pending sample, and guards each job with
// a watchdog so a hung engine cannot stall the sample path.
module attitude_angle_sched
    import attitude_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                smp_valid,
    input  logic [SAMPLE_W-1:0] smp_ax,
    input  logic [SAMPLE_W-1:0] smp_ay,
    input  logic [SAMPLE_W-1:0] smp_az,
    output logic                eng_start,
    output logic [SAMPLE_W-1:0] eng_x,
    output logic [SAMPLE_W-1:0] eng_y,
    output logic [SAMPLE_W-1:0] eng_z,
    input  logic                eng_done,
    input  logic [ANGLE_W-1:0]  eng_angle,
    output logic                att_valid,
    output logic [ANGLE_W-1:0]  pitch,
    output logic [ANGLE_W-1:0]  roll,
    output logic                busy,
    output logic [DROP_W-1:0]   drop_cnt,
    output logic                err_timeout,
    input  logic                err_clr
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    att_state_e          state_r;
    logic [SAMPLE_W-1:0] wx_r, wy_r, wz_r;
    logic [SAMPLE_W-1:0] eng_x_r, eng_y_r, eng_z_r;
    logic                eng_start_r;
    logic [ANGLE_W-1:0]  pitch_cap_r;
    logic [ANGLE_W-1:0]  pitch_r, roll_r;
    logic                att_valid_r;
    logic                busy_r;
    logic                err_r;
    logic [WD_W-1:0]     wd_r;

    logic                pv_s;
    logic [SAMPLE_W-1:0] px_s, py_s, pz_s;
    logic                idle_s, slot_wr_s, consume_s;
    logic                waiting_s, wd_hit_s, err_set_s;
    logic [WD_W-1:0]     wd_inc_s;

    // In IDLE with an empty slot a sample goes straight to the working
    // registers; everywhere else it lands in the pending slot.
    assign idle_s    = (state_r == S_IDLE);
    assign consume_s = idle_s && pv_s;
    assign slot_wr_s = smp_valid && (!idle_s || pv_s);

    assign waiting_s = (state_r == S_P_WAIT) || (state_r == S_R_WAIT);
    assign wd_inc_s  = wd_r + WD_W'(1);
    assign wd_hit_s  = (wd_inc_s == WD_W'(TIMEOUT_CYC));
    assign err_set_s = waiting_s && !eng_done && wd_hit_s;

    attitude_sample_slot u_slot (
        .clk      (clk),
        .rst      (rst),
        .wr       (slot_wr_s),
        .consume  (consume_s),
        .ax       (smp_ax),
        .ay       (smp_ay),
        .az       (smp_az),
        .pv       (pv_s),
        .px       (px_s),
        .py       (py_s),
        .pz       (pz_s),
        .drop_cnt (drop_cnt)
    );

    // Frame sequencer: pitch job, one-cycle gap, roll job, publish.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            wx_r        <= {SAMPLE_W{1'b0}};
            wy_r        <= {SAMPLE_W{1'b0}};
            wz_r        <= {SAMPLE_W{1'b0}};
            eng_x_r     <= {SAMPLE_W{1'b0}};
            eng_y_r     <= {SAMPLE_W{1'b0}};
            eng_z_r     <= {SAMPLE_W{1'b0}};
            eng_start_r <= 1'b0;
            pitch_cap_r <= {ANGLE_W{1'b0}};
            pitch_r     <= {ANGLE_W{1'b0}};
            roll_r      <= {ANGLE_W{1'b0}};
            att_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
            wd_r        <= {WD_W{1'b0}};
        end else begin
            eng_start_r <= 1'b0;
            att_valid_r <= 1'b0;
            // A timeout in the same cycle as a clear leaves the flag set.
            if (err_set_s) begin
                err_r <= 1'b1;
            end else if (err_clr) begin
                err_r <= 1'b0;
            end else begin
                err_r <= err_r;
            end
            case (state_r)
                S_IDLE: begin
                    if (pv_s) begin
                        wx_r        <= px_s;
                        wy_r        <= py_s;
                        wz_r        <= pz_s;
                        eng_x_r     <= px_s;
                        eng_y_r     <= py_s;
                        eng_z_r     <= pz_s;
                        eng_start_r <= 1'b1;
                        busy_r      <= 1'b1;
                        state_r     <= S_P_START;
                    end else if (smp_valid) begin
                        wx_r        <= smp_ax;
                        wy_r        <= smp_ay;
                        wz_r        <= smp_az;
                        eng_x_r     <= smp_ax;
                        eng_y_r     <= smp_ay;
                        eng_z_r     <= smp_az;
                        eng_start_r <= 1'b1;
                        busy_r      <= 1'b1;
                        state_r     <= S_P_START;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= S_IDLE;
                    end
                end
                S_P_START: begin
                    wd_r    <= {WD_W{1'b0}};
                    state_r <= S_P_WAIT;
                end
                S_P_WAIT: begin
                    if (eng_done) begin
                        pitch_cap_r <= eng_angle;
                        state_r     <= S_GAP;
                    end else if (wd_hit_s) begin
                        wd_r    <= wd_inc_s;
                        busy_r  <= 1'b0;
                        state_r <= S_IDLE;
                    end else begin
                        wd_r <= wd_inc_s;
                    end
                end
                S_GAP: begin
                    eng_x_r     <= wy_r;
                    eng_y_r     <= wx_r;
                    eng_z_r     <= wz_r;
                    eng_start_r <= 1'b1;
                    state_r     <= S_R_START;
                end
                S_R_START: begin
                    wd_r    <= {WD_W{1'b0}};
                    state_r <= S_R_WAIT;
                end
                S_R_WAIT: begin
                    if (eng_done) begin
                        pitch_r     <= pitch_cap_r;
                        roll_r      <= eng_angle;
                        att_valid_r <= 1'b1;
                        state_r     <= S_PUBLISH;
                    end else if (wd_hit_s) begin
                        wd_r    <= wd_inc_s;
                        busy_r  <= 1'b0;
                        state_r <= S_IDLE;
                    end else begin
                        wd_r <= wd_inc_s;
                    end
                end
                S_PUBLISH: begin
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign eng_start   = eng_start_r;
    assign eng_x       = eng_x_r;
    assign eng_y       = eng_y_r;
    assign eng_z       = eng_z_r;
    assign att_valid   = att_valid_r;
    assign pitch       = pitch_r;
    assign roll        = roll_r;
    assign busy        = busy_r;
    assign err_timeout = err_r;

endmodule

// File: tb/tb_attitude_angle_sched.sv
// Randomized and directed bench for attitude_angle_sched with a mock engine
// and a cycle-timing reference model of frame scheduling.
`timescale 1ns/1ps
module tb_attitude_angle_sched;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        smp_valid = 1'b0;
    logic [15:0] smp_ax = 16'd0, smp_ay = 16'd0, smp_az = 16'd0;
    logic        eng_start;
    logic [15:0] eng_x, eng_y, eng_z;
    logic        eng_done = 1'b0;
    logic [15:0] eng_angle = 16'd0;
    logic        att_valid;
    logic [15:0] pitch, roll;
    logic        busy;
    logic [7:0]  drop_cnt;
    logic        err_timeout;
    logic        err_clr = 1'b0;

    attitude_angle_sched #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .smp_valid(smp_valid),
        .smp_ax(smp_ax), .smp_ay(smp_ay), .smp_az(smp_az),
        .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y), .eng_z(eng_z),
        .eng_done(eng_done), .eng_angle(eng_angle),
        .att_valid(att_valid), .pitch(pitch), .roll(roll), .busy(busy),
        .drop_cnt(drop_cnt), .err_timeout(err_timeout), .err_clr(err_clr)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    int vec_cnt = 0;
    int miscmp_cnt = 0;

    task automatic check_value(input string tag, input logic signed [31:0] obs,
                               input logic signed [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: expected engine starts and publishes, keyed by cycle.
    typedef struct { int cyc; int x; int y; int z; } start_t;
    typedef struct { int cyc; int p; int r; } pub_t;
    start_t st_q[$];
    pub_t   pub_q[$];
    int cyc = 0, idle_cyc = 0, start_cyc = -1, err_cyc = -1;
    bit m_pv = 1'b0, m_err = 1'b0, checking = 1'b0, just_reset = 1'b0;
    int m_px, m_py, m_pz, m_drop = 0, m_pitch = 0, m_roll = 0;

    // Mock engine controls: latency, never-done, and stale done outside jobs.
    int mock_l = 5, mock_due = 0;
    bit mock_hang = 1'b0, mock_stale = 1'b0, mock_act = 1'b0;
    logic [15:0] mock_val = 16'd0;

    task automatic model_start(input int c, input int ax, input int ay, input int az);
        start_cyc = c;
        st_q.push_back('{c + 1, ax, ay, az});
        if (mock_hang) begin
            err_cyc  = c + 2 + TO;
            idle_cyc = c + 2 + TO;
        end else begin
            st_q.push_back('{c + 3 + mock_l, ay, ax, az});
            pub_q.push_back('{c + 4 + 2 * mock_l, ax, ay});
            idle_cyc = c + 5 + 2 * mock_l;
        end
    endtask

    // Per cycle: compare DUT outputs, drive the mock engine, advance the model.
    always @(negedge clk) begin
        bit exp_av, exp_st;
        if (checking) begin
            exp_av = (pub_q.size() > 0) && (pub_q[0].cyc == cyc);
            if (exp_av) begin
                m_pitch = pub_q[0].p;
                m_roll  = pub_q[0].r;
                void'(pub_q.pop_front());
            end
            check_value("att_valid", {31'd0, att_valid}, {31'd0, exp_av});
            check_value("pitch", $signed(pitch), m_pitch);
            check_value("roll", $signed(roll), m_roll);
            exp_st = (st_q.size() > 0) && (st_q[0].cyc == cyc);
            check_value("eng_start", {31'd0, eng_start}, {31'd0, exp_st});
            if (exp_st) begin
                check_value("eng_x", $signed(eng_x), st_q[0].x);
                check_value("eng_y", $signed(eng_y), st_q[0].y);
                check_value("eng_z", $signed(eng_z), st_q[0].z);
                void'(st_q.pop_front());
            end
            if (just_reset) begin
                check_value("rst_eng_x", $signed(eng_x), 0);
                check_value("rst_eng_y", $signed(eng_y), 0);
                check_value("rst_eng_z", $signed(eng_z), 0);
            end
            check_value("busy", {31'd0, busy}, {31'd0, (cyc > start_cyc) && (cyc < idle_cyc)});
            check_value("drop_cnt", {24'd0, drop_cnt}, m_drop);
            check_value("err_timeout", {31'd0, err_timeout}, {31'd0, m_err});
        end

        if (eng_start === 1'b1) begin
            mock_act = 1'b1;
            mock_due = cyc + mock_l;
            mock_val = eng_x;
        end
        if (mock_act && !mock_hang && cyc == mock_due) begin
            eng_done  = 1'b1;
            eng_angle = mock_val;
            mock_act  = 1'b0;
        end else if (!mock_act && mock_stale) begin
            eng_done  = 1'b1;
            eng_angle = 16'($urandom);
        end else begin
            eng_done  = 1'b0;
            eng_angle = 16'($urandom);
        end

        if (rst) begin
            mock_act = 1'b0;
            st_q.delete();
            pub_q.delete();
            m_pv = 1'b0; m_drop = 0; m_err = 1'b0; m_pitch = 0; m_roll = 0;
            idle_cyc = cyc + 1; start_cyc = cyc; err_cyc = -1;
            just_reset = 1'b1;
        end else begin
            just_reset = 1'b0;
            if (cyc + 1 == err_cyc) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
            if (cyc >= idle_cyc) begin
                if (m_pv) begin
                    model_start(cyc, m_px, m_py, m_pz);
                    m_pv = smp_valid;
                    if (smp_valid) begin
                        m_px = $signed(smp_ax); m_py = $signed(smp_ay); m_pz = $signed(smp_az);
                    end
                end else if (smp_valid) begin
                    model_start(cyc, $signed(smp_ax), $signed(smp_ay), $signed(smp_az));
                end
            end else if (smp_valid) begin
                if (m_pv && m_drop < 255) m_drop++;
                m_pv = 1'b1;
                m_px = $signed(smp_ax); m_py = $signed(smp_ay); m_pz = $signed(smp_az);
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        smp_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send(input logic [15:0] ax, input logic [15:0] ay, input logic [15:0] az);
        smp_ax = ax; smp_ay = ay; smp_az = az;
        smp_valid = 1'b1;
        tick();
        smp_valid = 1'b0;
    endtask

    task automatic send_rand();
        send(16'($urandom), 16'($urandom), 16'($urandom));
    endtask

    // Directed scenarios followed by randomized traffic.
    initial begin
        repeat (3) tick();
        rst = 1'b0;
        checking = 1'b1;
        idle(4);

        // Single sample, L=5.
        send(16'd100, -16'sd200, 16'd16384);
        idle(25);

        // Three samples in one frame: middle one is dropped.
        send_rand(); idle(3); send_rand(); idle(2); send_rand();
        idle(45);

        // Hung engine: timeout, clear, then timeout coinciding with clear.
        mock_hang = 1'b1;
        send_rand(); idle(20);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        idle(3);
        send_rand(); idle(15);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        idle(5);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        mock_hang = 1'b0;
        idle(5);

        // Stale done in IDLE, GAP and PUBLISH is ignored.
        mock_stale = 1'b1;
        idle(3);
        send(16'd100, -16'sd200, 16'd16384);
        idle(25);
        mock_stale = 1'b0;
        idle(5);

        // Reset during R_WAIT with a pending sample, then a clean frame.
        send_rand(); idle(2); send_rand(); idle(6);
        rst = 1'b1; tick(); rst = 1'b0;
        idle(3);
        send_rand();
        idle(25);

        // Sample arriving in the IDLE cycle that consumes the pending slot.
        send_rand(); idle(1); send_rand(); idle(12); send_rand();
        idle(50);

        // Continuous samples drive drop_cnt into saturation.
        repeat (700) send_rand();
        idle(50);

        // Randomized rounds with varying latency and engine behaviour.
        for (int r = 0; r < 10; r++) begin
            mock_l     = $urandom_range(1, 8);
            mock_hang  = (r % 4 == 3);
            mock_stale = (r % 3 == 1) && !mock_hang;
            for (int i = 0; i < 200; i++) begin
                smp_ax = 16'($urandom); smp_ay = 16'($urandom); smp_az = 16'($urandom);
                smp_valid = ($urandom_range(0, 5) == 0);
                err_clr   = ($urandom_range(0, 15) == 0);
                rst       = ($urandom_range(0, 149) == 0);
                tick();
            end
            rst = 1'b0; err_clr = 1'b0;
            idle(50);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule

// File: doc/attitude_angle_sched.md
# attitude_angle_sched

Scheduler that shares one `cordic_angle` engine between the pitch and roll computations for every accelerometer sample. It sits between the IMU sample path and the engine.

- It runs two engine jobs per sample, in a fixed order:
  - pitch = atan2(ax, sqrt(ay²+az²))
  - roll = atan2(ay, sqrt(ax²+az²))
- It holds one pending sample while busy.
- It publishes the pitch/roll pair with a one-cycle valid strobe.
- A watchdog recovers from a hung engine.

## Interface

Parameters:
- `TIMEOUT_CYC`, default 1023: maximum number of cycles a job may wait for `eng_done` before the frame is aborted.

Ports:
- `clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset. The same reset also resets the shared engine.
- `smp_valid` in 1: one-cycle strobe meaning a new sample is present.
- `smp_ax`, `smp_ay`, `smp_az` in 16 each: signed accelerometer sample, raw counts.
- `eng_start` out 1: start pulse to the engine.
- `eng_x`, `eng_y`, `eng_z` out 16 each: signed engine operands.
- `eng_done` in 1: engine completion pulse.
- `eng_angle` in 16: signed engine result.
- `att_valid` out 1: one-cycle strobe meaning `pitch`/`roll` have just been updated.
- `pitch`, `roll` out 16: signed, in engine angle units; held between updates.
- `busy` out 1: high whenever the state is not IDLE.
- `drop_cnt` out 8: saturating count of samples overwritten in the pending slot.
- `err_timeout` out 1: sticky watchdog flag.
- `err_clr` in 1: clears `err_timeout`.

## Operation

- States: IDLE, P_START, P_WAIT, GAP, R_START, R_WAIT, PUBLISH.
- Working registers `wx`, `wy`, `wz` are 16-bit signed. The pending slot is `pv` plus `px`, `py`, `pz`.
- Frame start (IDLE):
  - If `pv`=1: the pending sample moves into the working registers, `pv` clears, and the state goes to P_START.
  - In the same cycle, a simultaneous `smp_valid` writes the new sample into the pending slot (`pv`=1). This is not a drop.
  - If `pv`=0 and `smp_valid`=1: the sample goes directly into the working registers and the state goes to P_START.
- Pitch job:
  - P_START: `eng_start`=1, operands (x,y,z) = (`wx`,`wy`,`wz`); next state P_WAIT.
  - P_WAIT: on `eng_done`, capture `eng_angle` into the internal pitch register; next state GAP.
- GAP lasts one cycle so the engine can return to its idle state; next state R_START.
- Roll job:
  - R_START: `eng_start`=1, operands = (`wy`,`wx`,`wz`); next state R_WAIT.
  - R_WAIT: on `eng_done`, capture the roll value; next state PUBLISH.
- PUBLISH: `pitch` and `roll` outputs load the new pair, `att_valid`=1; next state IDLE.
- Operands stay stable from *_START through the end of the matching *_WAIT. `eng_start` is a Moore decode of the *_START states, so it is exactly one cycle wide.
- `eng_done` is honoured only in P_WAIT and R_WAIT. In any other state it is ignored, including a stale done left over from a run cut short by reset.
- Samples outside IDLE:
  - `smp_valid` with `pv`=0 fills the pending slot.
  - `smp_valid` with `pv`=1 overwrites the slot (latest wins) and increments `drop_cnt`, which saturates at 255.
- Watchdog:
  - The counter is `$clog2(TIMEOUT_CYC+1)` bits wide. It clears in each *_START state and increments every WAIT cycle without `eng_done`.
  - When it reaches `TIMEOUT_CYC`: `err_timeout`←1, the frame is discarded, the state goes to IDLE, there is no `att_valid`, and `pitch`/`roll` keep their old values.
- `err_clr` clears `err_timeout`. If a set and a clear happen in the same cycle, set wins.
- Width rule: `eng_angle` passes through to `pitch`/`roll` unchanged. There is no scaling, truncation or sign change.

## Timing

- Reset values: every output is 0; `pv`=0; state is IDLE; the watchdog counter is 0.
- A reset in any state aborts the frame and clears the pending slot and `drop_cnt`. Processing resumes normally with the first `smp_valid` after `rst` deasserts.
- Let sample capture be cycle T, and let the engine latency L be counted from the `eng_start` cycle to the `eng_done` cycle. Then:
  - P_START is at T+1 and pitch done at T+1+L.
  - R_START is at T+3+L and roll done at T+3+2L.
  - `att_valid` is at T+4+2L.
- The next frame can start at the earliest 1 cycle after PUBLISH (its IDLE cycle).
- `busy` is registered and equals (state ≠ IDLE).

## Structure

- Shared package `attitude_pkg` holds:
  - the state enum;
  - the angle width constant (16);
  - the sample width constant (16).
- One sub-module is natural: `attitude_sample_slot`, the single-entry latest-wins pending register with the saturating drop counter.
- The engine is instantiated outside this block so that other clients can reuse it.

## Test plan

All scenarios use a mock engine with L=5 that returns `eng_angle`=`eng_x`, unless stated otherwise.

1. Single sample ax=100, ay=-200, az=16384 at T:
   - pitch operands (100,-200,16384) at T+1;
   - roll operands (-200,100,16384) at T+8;
   - `att_valid` at T+14 with `pitch`=100, `roll`=-200.
2. Three samples during one frame (second and third both arrive while busy):
   - second is overwritten, `drop_cnt`=1;
   - exactly two `att_valid` strobes, the second carrying the third sample's values.
3. `TIMEOUT_CYC`=15, mock never asserts done:
   - `err_timeout`=1 sixteen cycles after P_START;
   - return to IDLE, no `att_valid`;
   - `err_clr` drives it back to 0.
4. `eng_done` forced high in IDLE and in GAP: no state change and no captured value; the frame result is unchanged from scenario 1.
5. `rst` pulsed in R_WAIT with `pv`=1:
   - all outputs return to 0, `pv`=0;
   - the next sample yields a correct frame with 14-cycle latency.
6. Sample with `smp_valid` arriving in the same IDLE cycle that consumes `pv`: no drop (`drop_cnt` unchanged); both frames are published in order.
